// File: rtl/seq_shift_unit_if.sv
// Handshake/data bundle for seq_shift_unit: command side (in_*), result side (out_*), busy flag.
interface seq_shift_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [4:0]       shamt;
  logic             op;
  logic             sra;
  logic             rotate;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             busy;

  modport master (
    output in_valid, a, shamt, op, sra, rotate, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, a, shamt, op, sra, rotate, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/seq_shift_unit.sv
// Multi-cycle 32-bit shift/rotate unit: coarse 4-bit then fine 1-bit steps, one step per clock.
// Optional macro SEQ_SHIFT_STEP16_EN adds a top-priority 16-bit step (same results, lower latency).
module seq_shift_unit #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned COARSE = 4
) (
  input logic               clk,
  input logic               rst,
  seq_shift_unit_if.slave   bus
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] data;
  logic [4:0]       rem;
  logic             op_r;
  logic             sra_r;
  logic             rot_r;
  logic [4:0]       step_amt;
  logic [5:0]       comp_amt;
  logic [WIDTH-1:0] stepped;

  // Largest step that does not exceed rem, so rem never underflows.
  always_comb begin
    step_amt = 5'd1;
`ifdef SEQ_SHIFT_STEP16_EN
    if (rem >= 5'd16)
      step_amt = 5'd16;
    else if (rem >= 5'(COARSE))
      step_amt = 5'(COARSE);
`else
    if (rem >= 5'(COARSE))
      step_amt = 5'(COARSE);
`endif
  end

  assign comp_amt = 6'(WIDTH) - {1'b0, step_amt};

  always_comb begin
    stepped = data;
    if (rot_r) begin
      if (op_r)
        stepped = (data >> step_amt) | (data << comp_amt);
      else
        stepped = (data << step_amt) | (data >> comp_amt);
    end else if (op_r) begin
      if (sra_r)
        stepped = $unsigned($signed(data) >>> step_amt);
      else
        stepped = data >> step_amt;
    end else begin
      stepped = data << step_amt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      data  <= '0;
      rem   <= '0;
      op_r  <= 1'b0;
      sra_r <= 1'b0;
      rot_r <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            data  <= bus.a;
            rem   <= bus.shamt;
            op_r  <= bus.op;
            sra_r <= bus.sra;
            rot_r <= bus.rotate;
            state <= (bus.shamt == 5'd0) ? S_DONE : S_SHIFT;
          end
        end
        S_SHIFT: begin
          data <= stepped;
          rem  <= rem - step_amt;
          if (rem == step_amt)
            state <= S_DONE;
        end
        S_DONE: begin
          if (bus.out_ready)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.busy      = (state == S_SHIFT) || (state == S_DONE);
  assign bus.out_valid = (state == S_DONE);
  assign bus.out_data  = (state == S_DONE) ? data : '0;
endmodule

// File: tb/tb_seq_shift_unit.sv
// Self-checking bench for seq_shift_unit: directed plan cases plus randomized commands vs. a reference model.
module tb_seq_shift_unit;
  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  seq_shift_unit_if #(.WIDTH(32)) bus ();

  seq_shift_unit #(.WIDTH(32), .COARSE(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [31:0] a, input int n,
                                              input logic op, input logic sra, input logic rot);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (rot) begin
        if (!op) r[(i + n) % 32] = a[i];
        else     r[(i + 32 - n) % 32] = a[i];
      end else if (!op) begin
        if (i + n < 32) r[i + n] = a[i];
      end else begin
        if (i + n < 32) r[i] = a[i + n];
        else            r[i] = sra ? a[31] : 1'b0;
      end
    end
    return r;
  endfunction

  function automatic int ref_latency(input int n);
`ifdef SEQ_SHIFT_STEP16_EN
    return n / 16 + (n % 16) / 4 + n % 4;
`else
    return n / 4 + n % 4;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble_inputs();
    bus.a      = $urandom;
    bus.shamt  = 5'($urandom_range(0, 31));
    bus.op     = 1'($urandom);
    bus.sra    = 1'($urandom);
    bus.rotate = 1'($urandom);
  endtask

  task automatic issue(input logic [31:0] a, input logic [4:0] n,
                       input logic op, input logic sra, input logic rot);
    int guard;
    bus.a = a; bus.shamt = n; bus.op = op; bus.sra = sra; bus.rotate = rot;
    bus.in_valid = 1'b1;
    guard = 0;
    while (!bus.in_ready && guard < 30) begin
      tick();
      guard++;
    end
    chk("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    scramble_inputs();
  endtask

  task automatic do_cmd(input string tag, input logic [31:0] a, input logic [4:0] n,
                        input logic op, input logic sra, input logic rot,
                        input logic [31:0] exp, input int hold, input bit compete);
    int lat;
    issue(a, n, op, sra, rot);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_latency"}, 32'(lat), 32'(ref_latency(int'(n))));
    chk({tag, "_data"}, bus.out_data, exp);
    chk({tag, "_in_ready_done"}, 32'(bus.in_ready), 32'd0);
    chk({tag, "_busy_done"}, 32'(bus.busy), 32'd1);
    for (int h = 0; h < hold; h++) begin
      if (compete && h == 0) bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      chk({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
      chk({tag, "_hold_data"}, bus.out_data, exp);
      chk({tag, "_hold_in_ready"}, 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk({tag, "_idle_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_idle_in_ready"}, 32'(bus.in_ready), 32'd1);
    chk({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int seen;
    logic [31:0] ra;
    logic [4:0]  rn;
    logic        rop, rsra, rrot;

    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    scramble_inputs();
    tick();
    tick();
    rst = 1'b0;
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_out_data", bus.out_data, 32'd0);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_in_ready", 32'(bus.in_ready), 32'd1);

    do_cmd("sll4",    32'h12345678, 5'd4,  1'b0, 1'b0, 1'b0, 32'h23456780, 0, 1'b0);
    do_cmd("sra8",    32'h87654321, 5'd8,  1'b1, 1'b1, 1'b0, 32'hFF876543, 0, 1'b0);
    do_cmd("srl8",    32'h87654321, 5'd8,  1'b1, 1'b0, 1'b0, 32'h00876543, 1, 1'b0);
    do_cmd("ror5",    32'hFEDCBA98, 5'd5,  1'b1, 1'b1, 1'b1, 32'hC7F6E5D4, 0, 1'b0);
    do_cmd("rol31",   32'h00000001, 5'd31, 1'b0, 1'b0, 1'b1, 32'h80000000, 0, 1'b0);
    do_cmd("zero",    32'hC0FFEE01, 5'd0,  1'b1, 1'b1, 1'b1, 32'hC0FFEE01, 0, 1'b0);
    do_cmd("backpr",  32'hABCDEF01, 5'd1,  1'b0, 1'b0, 1'b0, 32'h579BDE02, 3, 1'b1);

    // Reset mid-operation discards the in-flight command.
    issue(32'h13579BDF, 5'd31, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (bus.out_valid) seen++;
    end
    chk("midrst_no_output", 32'(seen), 32'd0);
    do_cmd("after_rst", 32'h98765432, 5'd4, 1'b1, 1'b1, 1'b0, 32'hF9876543, 0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      ra   = $urandom;
      rn   = 5'($urandom_range(0, 31));
      rop  = 1'($urandom);
      rsra = 1'($urandom);
      rrot = 1'($urandom);
      do_cmd("rand", ra, rn, rop, rsra, rrot, ref_result(ra, int'(rn), rop, rsra, rrot),
             int'($urandom_range(0, 2)), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
